// File: rtl/fc_neuron_stream.sv
`timescale 1ns/1ps
// fc_neuron_stream: one fully-connected neuron fed by a LANES-wide activation stream.
// Latency: last input beat accepted in cycle t -> valid_o high in cycle t+3.
// Backpressure: ready_o is low outside accumulation; the result holds on valid_o/data_o until ready_i.
//
// Ports:
//   clk_i, reset_i          clock and synchronous active-high reset
//   valid_i/ready_o/data_i  activation stream, lane k in data_i[k*WORD_SIZE +: WORD_SIZE]
//   weight_addr_o/weight_i  weight memory port (registered read); address BEATS holds the bias in lane 0
//   valid_o/ready_i/data_o  saturated neuron result
//
// Optional build macro FC_NEURON_RELU_EN: applies max(0, x) to the registered result.
module fc_neuron_stream #(
    parameter int WORD_SIZE             = 16,
    parameter int INT_BITS              = 8,
    parameter int PREVIOUS_LAYER_HEIGHT = 4,
    parameter int LANES                 = 1,
    localparam int BEATS                = PREVIOUS_LAYER_HEIGHT / LANES,
    localparam int AW                   = $clog2(BEATS + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [LANES*WORD_SIZE-1:0] data_i,
    output logic [AW-1:0]              weight_addr_o,
    input  logic [LANES*WORD_SIZE-1:0] weight_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [WORD_SIZE-1:0]       data_o
);

    localparam int FRAC  = WORD_SIZE - INT_BITS;
    localparam int PW    = 2 * WORD_SIZE;
    localparam int ACC_W = 2 * WORD_SIZE + $clog2(PREVIOUS_LAYER_HEIGHT + 2);

    localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (WORD_SIZE - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(1) <<< (WORD_SIZE - 1));

    typedef enum logic [1:0] {ACCUM, FETCH_BIAS, ADD_BIAS, OUT} state_t;

    state_t                     state_q, state_d;
    logic [AW-1:0]              beat_cnt_q, beat_cnt_d;
    logic [LANES*WORD_SIZE-1:0] act_q, act_d;
    logic                       pipe_vld_q, pipe_vld_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic                       valid_q, valid_d;
    logic [WORD_SIZE-1:0]       out_q, out_d;

    logic                       accept;
    logic signed [ACC_W-1:0]    lane_sum;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W-1:0]    acc_biased;
    logic signed [ACC_W-1:0]    shifted;
    logic [WORD_SIZE-1:0]       result;

    // Registered activations meet their weights one cycle after acceptance,
    // because the weight memory read is registered.
    always_comb begin
        logic signed [PW-1:0] a_ext;
        logic signed [PW-1:0] w_ext;
        lane_sum = '0;
        a_ext    = '0;
        w_ext    = '0;
        for (int k = 0; k < LANES; k++) begin
            a_ext    = PW'($signed(act_q[k*WORD_SIZE +: WORD_SIZE]));
            w_ext    = PW'($signed(weight_i[k*WORD_SIZE +: WORD_SIZE]));
            lane_sum = lane_sum + ACC_W'(a_ext * w_ext);
        end
    end

    // Bias is a WORD_SIZE fixed-point value; align it to the product's 2*FRAC scale.
    assign bias_ext   = ACC_W'($signed(weight_i[WORD_SIZE-1:0])) <<< FRAC;
    assign acc_biased = acc_q + bias_ext;
    assign shifted    = acc_biased >>> FRAC;

    always_comb begin
        result = shifted[WORD_SIZE-1:0];
        if (shifted > SAT_MAX) begin
            result = {1'b0, {(WORD_SIZE-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            result = {1'b1, {(WORD_SIZE-1){1'b0}}};
        end
`ifdef FC_NEURON_RELU_EN
        if (result[WORD_SIZE-1]) begin
            result = '0;
        end
`endif
    end

    // Input is refused during reset even though the state register already reads ACCUM.
    assign ready_o = (state_q == ACCUM) && !reset_i;
    assign accept  = valid_i && ready_o;

    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        act_d         = act_q;
        pipe_vld_d    = 1'b0;
        acc_d         = acc_q;
        valid_d       = valid_q;
        out_d         = out_q;
        weight_addr_o = AW'(BEATS);

        // Product stage drains whenever it holds a beat, including the FETCH_BIAS cycle.
        if (pipe_vld_q) begin
            acc_d = acc_q + lane_sum;
        end

        case (state_q)
            ACCUM: begin
                weight_addr_o = beat_cnt_q;
                if (accept) begin
                    act_d      = data_i;
                    pipe_vld_d = 1'b1;
                    beat_cnt_d = beat_cnt_q + AW'(1);
                    if (beat_cnt_q == AW'(BEATS - 1)) begin
                        state_d = FETCH_BIAS;
                    end
                end
            end
            FETCH_BIAS: begin
                state_d = ADD_BIAS;
            end
            ADD_BIAS: begin
                acc_d   = acc_biased;
                out_d   = result;
                valid_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (valid_q && ready_i) begin
                    valid_d    = 1'b0;
                    acc_d      = '0;
                    beat_cnt_d = '0;
                    state_d    = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ACCUM;
            beat_cnt_q <= '0;
            act_q      <= '0;
            pipe_vld_q <= 1'b0;
            acc_q      <= '0;
            valid_q    <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            act_q      <= act_d;
            pipe_vld_q <= pipe_vld_d;
            acc_q      <= acc_d;
            valid_q    <= valid_d;
            out_q      <= out_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = out_q;

endmodule

// File: tb/tb_fc_neuron_stream.sv
`timescale 1ns/1ps
module tb_fc_neuron_stream;

`ifdef FC_NEURON_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    // DUT1: LANES=1, H=4
    logic        v1;
    logic        r1;
    logic [15:0] d1;
    logic [2:0]  a1;
    logic [15:0] w1;
    logic        vo1;
    logic        ri1;
    logic [15:0] do1;

    // DUT2: LANES=2, H=4
    logic        v2;
    logic        r2;
    logic [31:0] d2;
    logic [1:0]  a2;
    logic [31:0] w2;
    logic        vo2;
    logic        ri2;
    logic [15:0] do2;

    logic [15:0] mem1 [5];
    logic [31:0] mem2 [3];
    logic [15:0] cur_d [4];

    fc_neuron_stream #(.WORD_SIZE(16), .INT_BITS(8), .PREVIOUS_LAYER_HEIGHT(4), .LANES(1)) u_dut1 (
        .clk_i(clk), .reset_i(rst), .valid_i(v1), .ready_o(r1), .data_i(d1),
        .weight_addr_o(a1), .weight_i(w1), .valid_o(vo1), .ready_i(ri1), .data_o(do1));

    fc_neuron_stream #(.WORD_SIZE(16), .INT_BITS(8), .PREVIOUS_LAYER_HEIGHT(4), .LANES(2)) u_dut2 (
        .clk_i(clk), .reset_i(rst), .valid_i(v2), .ready_o(r2), .data_i(d2),
        .weight_addr_o(a2), .weight_i(w2), .valid_o(vo2), .ready_i(ri2), .data_o(do2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered weight memories
    always @(posedge clk) begin
        w1 <= mem1[a1];
        w2 <= mem2[a2];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: real-valued dot product in 2^-16 units, floor to 2^-8, clamp, optional ReLU.
    function automatic logic [15:0] model();
        longint acc;
        acc = 0;
        for (int i = 0; i < 4; i++)
            acc += longint'($signed(cur_d[i])) * longint'($signed(mem1[i]));
        acc += longint'($signed(mem1[4])) * 256;
        acc = acc >>> 8;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        if (RELU && acc < 0) acc = 0;
        return 16'(acc);
    endfunction

    function automatic logic [15:0] rnd();
        logic signed [15:0] v;
        v = 16'($urandom);
        return v >>> $urandom_range(0, 9);
    endfunction

    task automatic run_vec(input string nm, input logic [15:0] exp, input int max_gap, input int stall);
        int t_last;
        int n;
        logic [15:0] held;
        t_last = 0;
        for (int b = 0; b < 4; b++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    v1 = 1'b0;
                    @(posedge clk); #1;
                end
            end
            v1 = 1'b1;
            d1 = cur_d[b];
            n = 0;
            while (!r1 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check({nm, "/rdy_addr"}, {28'd0, r1, a1}, {28'd0, 1'b1, 3'(b)});
            if (!r1) begin
                v1 = 1'b0;
                return;
            end
            t_last = cyc;
            @(posedge clk); #1;
        end
        v1 = 1'b0;
        n = 0;
        while (!vo1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "/valid"}, 32'(vo1), 32'd1);
        if (!vo1) return;
        check({nm, "/latency"}, 32'(cyc - t_last), 32'd3);
        check({nm, "/data"}, 32'(do1), 32'(exp));
        check({nm, "/bias_addr"}, 32'(a1), 32'd4);
        held = do1;
        ri1 = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check({nm, "/hold"}, {14'd0, vo1, r1, do1}, {14'd0, 1'b1, 1'b0, held});
        end
        ri1 = 1'b1;
        @(posedge clk); #1;
        ri1 = 1'b0;
        check({nm, "/release"}, {30'd0, vo1, r1}, {30'd0, 1'b0, 1'b1});
    endtask

    typedef struct {
        logic [15:0] d [4];
        logic [15:0] w [4];
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t  tbl [6];
    string names [6];

    task automatic load(input int i);
        for (int j = 0; j < 4; j++) begin
            cur_d[j] = tbl[i].d[j];
            mem1[j]  = tbl[i].w[j];
        end
        mem1[4] = tbl[i].b;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t2;
        int n;
        logic [15:0] e;

        names[0] = "basic";
        tbl[0].d = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        tbl[0].w = '{16'h0080, 16'h0080, 16'h0080, 16'h0080};
        tbl[0].b = 16'h0040; tbl[0].exp = 16'h0240;
        names[1] = "sat_pos";
        tbl[1].d = '{16'h6400, 16'h6400, 16'h6400, 16'h6400};
        tbl[1].w = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        tbl[1].b = 16'h0000; tbl[1].exp = 16'h7FFF;
        names[2] = "sat_neg";
        tbl[2].d = '{16'h6400, 16'h6400, 16'h6400, 16'h6400};
        tbl[2].w = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
        tbl[2].b = 16'h0000; tbl[2].exp = RELU ? 16'h0000 : 16'h8000;
        names[3] = "trunc";
        tbl[3].d = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
        tbl[3].w = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        tbl[3].b = 16'h0000; tbl[3].exp = RELU ? 16'h0000 : 16'hFFFF;
        names[4] = "zero_data";
        tbl[4].d = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[4].w = '{16'h0080, 16'h0080, 16'h0080, 16'h0080};
        tbl[4].b = 16'h0040; tbl[4].exp = 16'h0040;
        names[5] = "mixed";
        tbl[5].d = '{16'h0200, 16'hFF80, 16'h0100, 16'h0000};
        tbl[5].w = '{16'h0100, 16'h0200, 16'hFE00, 16'h7FFF};
        tbl[5].b = 16'h0010; tbl[5].exp = RELU ? 16'h0000 : 16'hFF10;

        for (int j = 0; j < 5; j++) mem1[j] = '0;
        for (int j = 0; j < 3; j++) mem2[j] = '0;
        rst = 1'b1; v1 = 1'b0; d1 = '0; ri1 = 1'b0; v2 = 1'b0; d2 = '0; ri2 = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_dut1", {14'd0, r1, vo1, do1}, 32'd0);
        check("reset_dut2", {14'd0, r2, vo2, do2}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_reset_ready", {30'd0, r1, r2}, 32'd3);

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            load(i);
            run_vec(names[i], tbl[i].exp, 0, 0);
        end

        // Input bubbles must not change the result
        load(0);
        run_vec("bubbles", 16'h0240, 3, 0);

        // Output stall of 5 cycles, then an all-zero vector proves acc was cleared
        load(0);
        run_vec("stall", 16'h0240, 0, 5);
        load(4);
        run_vec("after_stall", 16'h0040, 0, 0);

        // Reset after two accepted beats discards the partial sum
        load(0);
        for (int b = 0; b < 2; b++) begin
            v1 = 1'b1; d1 = 16'h7F00;
            @(posedge clk); #1;
        end
        v1 = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_reset", {14'd0, r1, vo1, do1}, 32'd0);
        rst = 1'b0;
        #1;
        run_vec("after_reset", 16'h0240, 0, 0);

        // LANES=2 instance
        mem2[0] = 32'h0100_0100;
        mem2[1] = 32'h0100_0100;
        mem2[2] = 32'h0000_FF00;
        t2 = 0;
        for (int b = 0; b < 2; b++) begin
            v2 = 1'b1;
            d2 = (b == 0) ? 32'h0200_0100 : 32'h0400_0300;
            check("lanes2/rdy_addr", {29'd0, r2, a2}, {29'd0, 1'b1, 2'(b)});
            t2 = cyc;
            @(posedge clk); #1;
        end
        v2 = 1'b0;
        n = 0;
        while (!vo2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("lanes2/latency", 32'(cyc - t2), 32'd3);
        check("lanes2/data", 32'(do2), 32'h0900);
        check("lanes2/bias_addr", 32'(a2), 32'd2);
        ri2 = 1'b1;
        @(posedge clk); #1;
        ri2 = 1'b0;
        check("lanes2/release", {30'd0, vo2, r2}, {30'd0, 1'b0, 1'b1});

        // Randomized vectors against the reference model
        for (int i = 0; i < 30; i++) begin
            for (int j = 0; j < 4; j++) begin
                cur_d[j] = rnd();
                mem1[j]  = rnd();
            end
            mem1[4] = rnd();
            e = model();
            run_vec("random", e, 2, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fc_neuron_stream.md
Name: fc_neuron_stream

Overview:
- Next-generation fully-connected neuron.
- Consumes the previous layer's activations as a valid/ready stream, LANES words per beat.
- Sequences its own weight/bias memory addresses and accumulates LANES products per cycle at full precision.
- Adds bias, saturates, and presents one result on a valid/ready output; the layer wrapper instantiates one per neuron with a shared registered weight memory port.

Parameters:
- WORD_SIZE, 16, activation/weight/bias width, signed fixed point.
- INT_BITS, 8, integer bits incl. sign; FRAC = WORD_SIZE-INT_BITS.
- PREVIOUS_LAYER_HEIGHT, 4, inputs per vector; must be a multiple of LANES.
- LANES, 1, input words and weights consumed per beat; BEATS = PREVIOUS_LAYER_HEIGHT/LANES.

Ports:
- clk_i  in  1  single clock, rising edge.
- reset_i  in  1  synchronous, active-high reset.
- valid_i  in  1  input beat valid.
- ready_o  out  1  input beat accepted when valid_i&&ready_o.
- data_i  in  LANES*WORD_SIZE  activations, lane k in bits [k*W +: W].
- weight_addr_o  out  $clog2(BEATS+1)  weight memory address; address BEATS holds bias.
- weight_i  in  LANES*WORD_SIZE  memory data, registered one cycle after weight_addr_o; bias in lane 0.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts result.
- data_o  out  WORD_SIZE  saturated neuron output.

Behaviour:
- Reset: state=ACCUM, beat_cnt=0, acc=0, pipe_valid=0, valid_o=0, data_o=0; ready_o=0 while reset_i high. Reset mid-operation discards all partial state.
- States: ACCUM -> FETCH_BIAS -> ADD_BIAS -> OUT -> ACCUM.
- ACCUM:
  - ready_o=1; weight_addr_o=beat_cnt.
  - On accept: register data_i, set pipe_valid, beat_cnt++.
  - The cycle after acceptance, weight_i matches that beat; acc += sum over lanes of data_reg[k]*weight_i[k].
  - Gaps in valid_i are legal; address holds until accept.
  - Accept of beat BEATS-1 -> FETCH_BIAS.
- FETCH_BIAS (1 cycle): ready_o=0; weight_addr_o=BEATS; final product stage drains into acc.
- ADD_BIAS (1 cycle): acc += sign_extend(weight_i lane 0) << FRAC.
- OUT:
  - On entry, data_o is registered = sat(acc >>> FRAC) and valid_o=1.
  - data_o/valid_o are held stable while ready_i=0.
  - On valid_o&&ready_i: valid_o=0, acc=0, beat_cnt=0 -> ACCUM.
  - ready_o stays 0 in OUT; no overlap with the next vector.
- Address: weight_addr_o=BEATS in FETCH_BIAS, ADD_BIAS, OUT.
- Arithmetic:
  - Products are 2*WORD_SIZE signed with 2*FRAC fraction bits.
  - acc width = 2*WORD_SIZE+$clog2(PREVIOUS_LAYER_HEIGHT+2), so it never overflows.
  - Shift is arithmetic: truncation toward -inf.
  - sat clamps to [-2^(W-1), 2^(W-1)-1].
- Latency: last beat accepted in cycle t -> valid_o high in cycle t+3.
- Throughput: one vector per BEATS+3 cycles plus any output stall.
- Simultaneous ready_i with OUT entry is not possible, since valid_o rises on entry; ready_i is ignored when valid_o=0.

Optional Feature:
- Macro FC_NEURON_RELU_EN.
- Defined: data_o = max(0, sat(acc>>>FRAC)), a fused ReLU on the registered output.
- Undefined: signed saturated value passed unchanged.
- Latency and handshakes are identical either way.

Test Plan:
- Basic (W=16, INT=8, H=4, LANES=1): data all 0x0100 (1.0), weights 0x0080 (0.5), bias 0x0040 (0.25).
  - data_o=0x0240 (2.25).
  - weight_addr_o sequence 0,1,2,3,4.
  - valid_o 3 cycles after the 4th accept.
- Saturation: data 0x6400 (100.0), weights 0x0100, bias 0.
  - data_o=0x7FFF.
  - With weights 0xFF00 (-1.0): 0x8000 without the macro, 0x0000 with FC_NEURON_RELU_EN.
- LANES=2, H=4: two beats {0x0100,0x0200}, {0x0300,0x0400}; weights all 0x0100; bias 0xFF00.
  - data_o=0x0900 (9.0).
  - weight_addr_o 0,1,2.
- Backpressure/gaps:
  - Random valid_i bubbles give the same result as test 1.
  - With ready_i low 5 cycles in OUT, valid_o and data_o are held and ready_o=0.
  - The next vector (data 0) then yields data_o=0x0040, proving acc cleared.
- Truncation: a single product of 0x0001*0xFFFF (-2^-16 real), with bias 0, gives data_o=0xFFFF (floor toward -inf).
- Reset mid-vector: assert reset_i after 2 accepted beats.
  - valid_o=0, data_o=0, ready_o=0 during reset.
  - A subsequent full vector from test 1 yields 0x0240.
